// File: rtl/dtc_pe_pkg.sv
// Shared helpers for the sparse dot-product PE: log2, pipeline latency
// and adder-tree output width.
package dtc_pe_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Multiplier stage + one register per tree level + accumulator stage
  function automatic int pe_latency(input int n_mul);
    return 2 + clog2(n_mul);
  endfunction

  function automatic int tree_sum_width(input int dw_prod, input int n_mul);
    return dw_prod + clog2(n_mul);
  endfunction

endpackage

// File: rtl/dtc_adder_tree_int.sv
// Signed pipelined pairwise adder tree, one register per level, with a
// valid/first/last sideband delayed in lockstep with the data.
module dtc_adder_tree_int import dtc_pe_pkg::*; #(
  parameter int NUM_IN = 8,
  parameter int DW_IN  = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic                                in_first,
  input  logic                                in_last,
  input  logic [NUM_IN*DW_IN-1:0]             in_data,
  output logic                                out_valid,
  output logic                                out_first,
  output logic                                out_last,
  output logic signed [DW_IN+clog2(NUM_IN)-1:0] out_sum
);

  localparam int LEVELS = clog2(NUM_IN);

  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] fst_q;
  logic [LEVELS-1:0] lst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      fst_q[0] <= in_first;
      lst_q[0] <= in_last;
      for (int k = 1; k < LEVELS; k++) begin
        vld_q[k] <= vld_q[k-1];
        fst_q[k] <= fst_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  // Level l holds NUM_IN>>l nodes, each one bit wider than the level below
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W  = DW_IN + l;
    localparam int NN = NUM_IN >> l;
    logic signed [W-1:0] node [NN];

    if (l == 0) begin : g_src
      always_comb begin
        for (int n = 0; n < NN; n++) begin
          node[n] = in_data[DW_IN*n +: DW_IN];
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int n = 0; n < NN; n++) begin
            node[n] <= '0;
          end
        end else begin
          for (int n = 0; n < NN; n++) begin
            node[n] <= W'(g_lvl[l-1].node[2*n]) + W'(g_lvl[l-1].node[2*n+1]);
          end
        end
      end
    end
  end

  assign out_sum   = g_lvl[LEVELS].node[0];
  assign out_valid = vld_q[LEVELS-1];
  assign out_first = fst_q[LEVELS-1];
  assign out_last  = lst_q[LEVELS-1];

endmodule

// File: rtl/dtc_pe_acc.sv
// Signed dot-product PE: masked multiplier bank, pipelined adder tree and
// a wrapping multi-beat accumulator with sticky signed-overflow flag.
module dtc_pe_acc import dtc_pe_pkg::*; #(
  parameter int N_MUL  = 8,
  parameter int DW_EL  = 16,
  parameter int DW_ACC = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N_MUL*DW_EL-1:0] in_a,
  input  logic [N_MUL*DW_EL-1:0] in_b,
  input  logic [N_MUL-1:0]       in_mask,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  output logic [DW_ACC-1:0]      out_data,
  output logic                   out_ovf
);

  localparam int DW_PROD = 2 * DW_EL;
  localparam int DW_SUM  = tree_sum_width(DW_PROD, N_MUL);

  logic [N_MUL*DW_PROD-1:0] prod_d;
  logic [N_MUL*DW_PROD-1:0] prod_q;
  logic                     m_valid;
  logic                     m_first;
  logic                     m_last;

  for (genvar i = 0; i < N_MUL; i++) begin : g_lane
    logic signed [DW_EL-1:0]   ea;
    logic signed [DW_EL-1:0]   eb;
    logic signed [DW_PROD-1:0] p;
    assign ea = in_a[DW_EL*i +: DW_EL];
    assign eb = in_b[DW_EL*i +: DW_EL];
    assign p  = ea * eb;
    assign prod_d[DW_PROD*i +: DW_PROD] = in_mask[i] ? p : '0;
  end

  // first/last are qualified here so the sideband never carries stale flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      m_valid <= 1'b0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      m_valid <= in_valid;
      m_first <= in_valid & in_first;
      m_last  <= in_valid & in_last;
    end
  end

  logic                     t_valid;
  logic                     t_first;
  logic                     t_last;
  logic signed [DW_SUM-1:0] t_sum;

  dtc_adder_tree_int #(
    .NUM_IN (N_MUL),
    .DW_IN  (DW_PROD)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_valid),
    .in_first  (m_first),
    .in_last   (m_last),
    .in_data   (prod_q),
    .out_valid (t_valid),
    .out_first (t_first),
    .out_last  (t_last),
    .out_sum   (t_sum)
  );

  logic signed [DW_ACC-1:0] acc_q;
  logic                     ovf_q;
  logic signed [DW_ACC-1:0] sum_ext;
  logic signed [DW_ACC-1:0] acc_next;
  logic                     add_ovf;

  assign sum_ext  = DW_ACC'(t_sum);
  assign acc_next = acc_q + sum_ext;
  // Overflow: operands share a sign and the wrapped result does not
  assign add_ovf  = (acc_q[DW_ACC-1] == sum_ext[DW_ACC-1]) &&
                    (acc_next[DW_ACC-1] != acc_q[DW_ACC-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= t_valid & t_last;
      if (t_valid) begin
        if (t_first) begin
          acc_q <= sum_ext;
          ovf_q <= 1'b0;
        end else begin
          acc_q <= acc_next;
          ovf_q <= ovf_q | add_ovf;
        end
      end
    end
  end

  assign out_data = acc_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_dtc_pe_acc.sv
// Scoreboard bench for dtc_pe_acc: a 48-bit and a 35-bit accumulator
// instance driven from shared data with per-instance valid.
module tb_dtc_pe_acc;

  typedef struct {
    longint data;
    longint ovf;
    longint cyc;
    string  name;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         v48;
  logic         v35;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic [7:0]   in_mask;
  logic         in_first;
  logic         in_last;
  logic         ov48;
  logic         ov35;
  logic [47:0]  od48;
  logic [34:0]  od35;
  logic         of48;
  logic         of35;

  int   checks;
  int   errors;
  int   cyc;
  exp_t q48[$];
  exp_t q35[$];

  dtc_pe_acc #(.N_MUL(8), .DW_EL(16), .DW_ACC(48)) dut48 (
    .clk(clk), .rst(rst), .in_valid(v48), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_first(in_first), .in_last(in_last),
    .out_valid(ov48), .out_data(od48), .out_ovf(of48)
  );

  dtc_pe_acc #(.N_MUL(8), .DW_EL(16), .DW_ACC(35)) dut35 (
    .clk(clk), .rst(rst), .in_valid(v35), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_first(in_first), .in_last(in_last),
    .out_valid(ov35), .out_data(od35), .out_ovf(of35)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] all_lanes(input logic signed [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] lane0(input logic signed [15:0] v);
    logic [127:0] r;
    r = '0;
    r[15:0] = v;
    return r;
  endfunction

  function automatic logic [127:0] seq_lanes();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(i + 1);
    return r;
  endfunction

  task automatic checkOutput(input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  // Drive one beat on the next falling edge; result due L=5 cycles later
  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b,
                               input logic [7:0] mask, input logic first,
                               input logic last, input int tgt, input bit push,
                               input longint exp_data, input longint exp_ovf,
                               input string name);
    exp_t e;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_mask  = mask;
    in_first = first;
    in_last  = last;
    v48      = (tgt == 0);
    v35      = (tgt == 1);
    if (push) begin
      e.data = exp_data;
      e.ovf  = exp_ovf;
      e.cyc  = cyc + 5;
      e.name = name;
      if (tgt == 0) q48.push_back(e);
      else          q35.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v48      = 1'b0;
      v35      = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov48) begin
      if (q48.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected48: out_valid at cycle %0d, data %0d, none expected",
                 cyc, $signed(od48));
      end else begin
        e = q48.pop_front();
        checkOutput({e.name, " data"}, longint'($signed(od48)), e.data);
        checkOutput({e.name, " ovf"}, longint'(of48), e.ovf);
        checkOutput({e.name, " cycle"}, longint'(cyc), e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov35) begin
      if (q35.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected35: out_valid at cycle %0d, data %0d, none expected",
                 cyc, $signed(od35));
      end else begin
        e = q35.pop_front();
        checkOutput({e.name, " data"}, longint'($signed(od35)), e.data);
        checkOutput({e.name, " ovf"}, longint'(of35), e.ovf);
        checkOutput({e.name, " cycle"}, longint'(cyc), e.cyc);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    v48      = 1'b0;
    v35      = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_mask  = '0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset valid48", longint'(ov48), 0);
    checkOutput("reset data48", longint'(od48), 0);
    checkOutput("reset ovf48", longint'(of48), 0);
    checkOutput("reset valid35", longint'(ov35), 0);
    checkOutput("reset data35", longint'(od35), 0);
    checkOutput("reset ovf35", longint'(of35), 0);
    rst = 1'b0;
    idle(2);

    applyStimulus(all_lanes(3), all_lanes(4), 8'hFF, 1, 1, 0, 1, 96, 0, "single");
    idle(8);

    applyStimulus(seq_lanes(), all_lanes(1), 8'h0F, 1, 1, 0, 1, 10, 0, "mask0f");
    applyStimulus(seq_lanes(), all_lanes(1), 8'h00, 1, 1, 0, 1, 0, 0, "mask00");
    idle(8);

    applyStimulus(all_lanes(-32768), all_lanes(-32768), 8'hFF, 1, 1, 0, 1,
                  64'sd8589934592, 0, "negneg");
    applyStimulus(all_lanes(-32768), all_lanes(32767), 8'hFF, 1, 1, 0, 1,
                  -64'sd8589672448, 0, "negpos");
    idle(8);

    applyStimulus(lane0(10), all_lanes(1), 8'hFF, 1, 0, 0, 0, 0, 0, "");
    idle(2);
    applyStimulus(lane0(-3), all_lanes(1), 8'hFF, 0, 0, 0, 0, 0, 0, "");
    idle(2);
    applyStimulus(lane0(5), all_lanes(1), 8'hFF, 0, 1, 0, 1, 12, 0, "bubbles");
    applyStimulus(lane0(7), all_lanes(1), 8'hFF, 1, 1, 0, 1, 7, 0, "backtoback");
    idle(8);

    applyStimulus(lane0(5), all_lanes(1), 8'hFF, 0, 1, 0, 1, 12, 0, "continue");
    idle(8);

    applyStimulus(lane0(10), all_lanes(1), 8'hFF, 1, 0, 0, 0, 0, 0, "");
    applyStimulus(lane0(4), all_lanes(1), 8'hFF, 1, 1, 0, 1, 4, 0, "restart");
    idle(8);

    applyStimulus(all_lanes(-32768), all_lanes(-32768), 8'hFF, 1, 0, 1, 0, 0, 0, "");
    applyStimulus(all_lanes(-32768), all_lanes(-32768), 8'hFF, 0, 1, 1, 1,
                  -64'sd17179869184, 1, "ovf35");
    applyStimulus(lane0(1), all_lanes(1), 8'hFF, 1, 1, 1, 1, 1, 0, "ovfclear35");
    idle(8);

    applyStimulus(lane0(3), all_lanes(1), 8'hFF, 1, 0, 0, 0, 0, 0, "");
    applyStimulus(lane0(4), all_lanes(1), 8'hFF, 0, 1, 0, 0, 0, 0, "");
    @(negedge clk);
    v48 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset valid48", longint'(ov48), 0);
    rst = 1'b0;
    idle(10);
    applyStimulus(lane0(7), all_lanes(1), 8'hFF, 1, 1, 0, 1, 7, 0, "afterreset");
    idle(20);

    checkOutput("pending48", longint'(q48.size()), 0);
    checkOutput("pending35", longint'(q35.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtc_pe_acc.md
Name: dtc_pe_acc

Overview:
Parametrised signed-integer dot-product PE with per-lane sparsity mask, valid-qualified input and multi-beat accumulation. Each valid beat multiplies N_MUL element pairs into a registered product bank. A pipelined adder tree reduces the products, and a DW_ACC-bit accumulator adds successive beats, so a long dot product streams through in K/N_MUL chunks. It is the successor to the fixed 8-lane single-shot PE and feeds the tile output buffer of the sparse tensor core.

Parameters:
N_MUL, 8, lane count; power of 2, >= 2
DW_EL, 16, signed element width of a and b
DW_PROD, 2*DW_EL, product width (derived, not overridable)
DW_ACC, 48, accumulator/output width; must be >= DW_PROD + log2(N_MUL)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  beat valid
in_a  in  N_MUL*DW_EL  lane i at [DW_EL*i +: DW_EL], signed
in_b  in  N_MUL*DW_EL  same packing, signed
in_mask  in  N_MUL  1 = lane active, 0 = lane contributes zero
in_first  in  1  beat starts a new accumulation
in_last  in  1  beat ends the accumulation
out_valid  out  1  one-cycle pulse, result present
out_data  out  DW_ACC  signed accumulated result
out_ovf  out  1  sticky signed overflow flag for this result

Behaviour:
- Reset is asynchronous, active-high, using rst and clk as already decided. All pipeline valid bits, product registers, tree registers and the accumulator clear to 0. Outputs reset to out_valid=0, out_data=0, out_ovf=0.
- There is no backpressure. The block accepts a beat on every cycle in which in_valid=1. in_first, in_last and in_mask are sampled only when in_valid=1.
- Stage M (1 cycle): prod[i] <= mask[i] ? a[i]*b[i] : 0. The product is full DW_PROD, signed. Valid, first and last are registered alongside it.
- Tree: log2(N_MUL) registered levels of pairwise adds. Each level grows the width by 1 bit and is signed-extended. The valid, first and last sideband is delayed in lockstep.
- Stage A (1 cycle): on a tree-output beat with valid=1:
  - If first=1: acc <= sext(sum) and ovf <= 0.
  - Otherwise: acc <= acc + sext(sum), wrapping modulo 2^DW_ACC. ovf <= ovf OR signed-overflow(acc, sum).
- Stage A with valid=0: acc and ovf hold.
- out_data = acc register, out_ovf = ovf register.
- out_valid <= tree-valid AND tree-last, so it pulses for one cycle. out_data and out_ovf are meaningful only while out_valid=1 and hold otherwise.
- Latency from the in_valid cycle t of the last beat to out_valid is L = 2 + log2(N_MUL). For N_MUL=8 this is cycle t+5.
- Full throughput is one beat per cycle. Bubbles (in_valid=0) may appear anywhere inside an accumulation and do not alter the result.
- in_first=1 and in_last=1 on the same beat gives a single-beat result.
- A beat without in_first following a completed result accumulates onto that previous value. This is defined behaviour, not an error.
- in_first arriving mid-accumulation discards the partial sum; no out_valid is produced for the discarded group.
- Back-to-back groups (last on cycle t, first on t+1) must both produce correct results, with out_valid high on consecutive cycles.
- Reset mid-operation discards all in-flight beats. No out_valid is produced for them, including after rst deasserts.

Decomposition:
- Package dtc_pe_pkg holds:
  - clog2 function;
  - the latency constant function L(N_MUL);
  - the tree sum width function DW_PROD + clog2(N_MUL).
- Sub-module dtc_adder_tree_int:
  - parameters NUM_IN and DW_IN; signed, pipelined, one register per level;
  - carries a 1-bit-per-level valid/first/last sideband;
  - reset behaviour identical to the parent.
- The parent holds the multiplier bank, the accumulator and overflow logic.

Test Plan:
- Single beat: N_MUL=8, a=3 and b=4 on all lanes, mask=0xFF, first=last=1 at cycle t -> out_valid only at t+5, out_data=96, out_ovf=0.
- Mask: a[i]=i+1, b=1, mask=0x0F -> out_data=10; with mask=0x00 -> out_data=0.
- Signed extremes: a=b=-32768 on all lanes -> out_data=8589934592 (2^33). With a=-32768, b=32767 on all lanes -> out_data=-8*1073709056.
- Multi-beat with bubbles: three beats with sums 10, -3, 5 (first on beat 1, last on beat 3), 2 idle cycles between beats -> a single out_valid with out_data=12. A back-to-back next group with sum 7 -> out_valid on the following cycle with 7.
- Overflow: DW_ACC=35, two beats each summing 2^33 -> out_data=-2^34, out_ovf=1. The next group (sum 1) -> out_ovf=0.
- Reset mid-operation: two beats of a group issued, then rst pulsed for 1 cycle while in flight -> no out_valid. A following first/last beat with sum 7 -> out_data=7.
